// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch stage with a PC generator feeding a
// DEPTH-entry prefetch FIFO between instruction memory and decode.
// Fetch runs ahead while decode stalls. A taken-branch redirect flushes
// the queue and reloads the fetch PC in one cycle.
// Optional feature macro: FETCH_QUEUE_BYPASS_EN. When it is defined, a word
// fetched into an empty queue is shown to decode in the same cycle.
module fetch_queue #(
   parameter int unsigned      XLEN     = 32,
   parameter int unsigned      DEPTH    = 4,
   parameter logic [XLEN-1:0]  RESET_PC = '0
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       start_i,
   input  logic                       redirect_i,
   input  logic [XLEN-1:0]            redirect_pc_i,
   output logic [XLEN-1:0]            imem_addr_o,
   input  logic [XLEN-1:0]            imem_instr_i,
   input  logic                       stall_i,
   output logic                       valid_o,
   output logic [XLEN-1:0]            pc_o,
   output logic [XLEN-1:0]            instr_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);

   // Clearing the low two bits with a mask keeps every target bit in the
   // expression. Synthesis then removes the two constant-zero bits.
   localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
   localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } fetchState_e;

   fetchState_e      state_q,   state_d;
   logic [XLEN-1:0]  fetchPc_q, fetchPc_d;
   logic [PW-1:0]    rdPtr_q,   rdPtr_d;
   logic [PW-1:0]    wrPtr_q,   wrPtr_d;
   logic [CW-1:0]    count_q,   count_d;

   logic [XLEN-1:0]  pcMem_q    [DEPTH];
   logic [XLEN-1:0]  instrMem_q [DEPTH];

   logic empty;
   logic full;
   logic canFetch;
   logic bypassHit;
   logic pop;
   logic push;
   logic doWrite;
   logic doRead;

   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));

   // A fetch can issue only while running with the enable held high and no
   // flush pending. Whether it actually pushes also depends on room.
   assign canFetch = (state_q == RUN) & start_i & ~redirect_i;

`ifdef FETCH_QUEUE_BYPASS_EN
   // The word being fetched into an empty queue is forwarded straight to
   // decode.
   assign bypassHit = empty & canFetch;
`else
   assign bypassHit = 1'b0;
`endif

   assign valid_o = ~empty | bypassHit;
   assign pop     = valid_o & ~stall_i & ~redirect_i;

   // When the queue is full, valid_o is already high from occupancy. A pop
   // in that case reduces to ~stall_i. Writing it this way keeps push
   // independent of the bypass path and avoids a combinational loop.
   assign push = canFetch & (~full | ~stall_i);

   // A bypassed word that decode consumes at once never lands in the queue.
   // It is also not read back out of the queue.
   assign doWrite = push & ~(bypassHit & pop);
   assign doRead  = pop & ~empty;

   // Next-state logic: a flush wins over everything except reset. Otherwise
   // the fetch PC, pointers and occupancy follow the push/pop decision.
   always_comb begin
      state_d   = state_q;
      fetchPc_d = fetchPc_q;
      rdPtr_d   = rdPtr_q;
      wrPtr_d   = wrPtr_q;
      count_d   = count_q;
      if (redirect_i) begin
         fetchPc_d = redirect_pc_i & ALIGN_MASK;
         rdPtr_d   = '0;
         wrPtr_d   = '0;
         count_d   = '0;
      end else begin
         unique case (state_q)
            IDLE:    if (start_i)  state_d = RUN;
            RUN:     if (!start_i) state_d = IDLE;
            default: state_d = IDLE;
         endcase
         if (push) begin
            fetchPc_d = fetchPc_q + PC_STEP;
         end
         if (doWrite) begin
            wrPtr_d = wrPtr_q + PW'(1);
         end
         if (doRead) begin
            rdPtr_d = rdPtr_q + PW'(1);
         end
         count_d = count_q + CW'(doWrite) - CW'(doRead);
      end
   end

   // Control registers, restored to the post-reset fetch position.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         fetchPc_q <= RESET_PC;
         rdPtr_q   <= '0;
         wrPtr_q   <= '0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         fetchPc_q <= fetchPc_d;
         rdPtr_q   <= rdPtr_d;
         wrPtr_q   <= wrPtr_d;
         count_q   <= count_d;
      end
   end

   // Queue storage. Entries are meaningless until occupancy covers them, so
   // they need no reset.
   always_ff @(posedge clk_i) begin
      if (!rst_i && doWrite) begin
         pcMem_q[wrPtr_q]    <= fetchPc_q;
         instrMem_q[wrPtr_q] <= imem_instr_i;
      end
   end

   // Head presentation: prefer the stored head, then the bypassed word, and
   // drive zeros when nothing is valid.
   always_comb begin
      pc_o    = '0;
      instr_o = '0;
      if (!empty) begin
         pc_o    = pcMem_q[rdPtr_q];
         instr_o = instrMem_q[rdPtr_q];
      end else if (bypassHit) begin
         pc_o    = fetchPc_q;
         instr_o = imem_instr_i;
      end
   end

   assign imem_addr_o = fetchPc_q;
   assign count_o     = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue. The bench compares the design, cycle by cycle,
// against a queue-based reference model of the fetch stage. It uses directed
// scenarios followed by randomized traffic.
// The model follows FETCH_QUEUE_BYPASS_EN in the same way the design does.
module tb_fetch_queue;

   localparam logic [31:0] RESET_PC = 32'h0;

   logic        clk;
   logic        rstIn;
   logic        startIn;
   logic        redirectIn;
   logic [31:0] redirectPcIn;
   logic [31:0] imemAddr;
   logic [31:0] imemInstr;
   logic        stallIn;
   logic        validOut;
   logic [31:0] pcOut;
   logic [31:0] instrOut;
   logic [2:0]  countOut;

   int checkCount = 0;
   int passCount  = 0;

   logic [31:0] modelPcQ[$];
   logic [31:0] modelInstrQ[$];
   bit          modelRun;
   logic [31:0] modelFetchPc;

   fetch_queue #(
      .XLEN(32),
      .DEPTH(4),
      .RESET_PC(RESET_PC)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rstIn),
      .start_i      (startIn),
      .redirect_i   (redirectIn),
      .redirect_pc_i(redirectPcIn),
      .imem_addr_o  (imemAddr),
      .imem_instr_i (imemInstr),
      .stall_i      (stallIn),
      .valid_o      (validOut),
      .pc_o         (pcOut),
      .instr_o      (instrOut),
      .count_o      (countOut)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Combinational instruction memory: a fixed scramble of the address
   function automatic logic [31:0] memWord(input logic [31:0] a);
      return {a[15:0] ^ 16'hC3A5, a[31:16] + 16'h1357} ^ 32'h0000_0013;
   endfunction

   assign imemInstr = memWord(imemAddr);

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                  tag, observed, expected, $time);
      end
   endtask

   task automatic modelReset();
      modelPcQ.delete();
      modelInstrQ.delete();
      modelRun     = 1'b0;
      modelFetchPc = RESET_PC;
   endtask

   // Drive one cycle of inputs, check outputs against the model, then
   // advance the model to the state it will have after the next edge
   task automatic applyStimulus(input bit rst, input bit start, input bit redir,
                                input logic [31:0] target, input bit stall);
      bit          bypassOk;
      bit          expValid;
      logic [31:0] expPc;
      logic [31:0] expInstr;
      bit          doPop;
      bit          doPush;
      int          sizeBefore;

      @(negedge clk);
      rstIn        = rst;
      startIn      = start;
      redirectIn   = redir;
      redirectPcIn = target;
      stallIn      = stall;
      #1;

`ifdef FETCH_QUEUE_BYPASS_EN
      bypassOk = (modelPcQ.size() == 0) && modelRun && start && !redir;
`else
      bypassOk = 1'b0;
`endif
      expValid = (modelPcQ.size() > 0) || bypassOk;
      expPc    = 32'h0;
      expInstr = 32'h0;
      if (modelPcQ.size() > 0) begin
         expPc    = modelPcQ[0];
         expInstr = modelInstrQ[0];
      end else if (bypassOk) begin
         expPc    = modelFetchPc;
         expInstr = memWord(modelFetchPc);
      end

      checkOutput("valid", 32'(validOut), 32'(expValid));
      checkOutput("pc", pcOut, expPc);
      checkOutput("instr", instrOut, expInstr);
      checkOutput("count", 32'(countOut), 32'(modelPcQ.size()));
      checkOutput("imemAddr", imemAddr, modelFetchPc);

      if (rst) begin
         modelReset();
      end else if (redir) begin
         modelPcQ.delete();
         modelInstrQ.delete();
         modelFetchPc = {target[31:2], 2'b00};
      end else begin
         sizeBefore = modelPcQ.size();
         doPop  = expValid && !stall;
         doPush = modelRun && start && (sizeBefore < 4 || doPop);
         if (doPop && sizeBefore > 0) begin
            void'(modelPcQ.pop_front());
            void'(modelInstrQ.pop_front());
         end
         if (doPush) begin
            if (!(doPop && sizeBefore == 0)) begin
               modelPcQ.push_back(modelFetchPc);
               modelInstrQ.push_back(memWord(modelFetchPc));
            end
            modelFetchPc = modelFetchPc + 32'd4;
         end
         if (!modelRun && start) begin
            modelRun = 1'b1;
         end else if (modelRun && !start) begin
            modelRun = 1'b0;
         end
      end
   endtask

   initial begin
      rstIn        = 1'b1;
      startIn      = 1'b0;
      redirectIn   = 1'b0;
      redirectPcIn = 32'h0;
      stallIn      = 1'b0;
      repeat (2) @(posedge clk);
      modelReset();

      $display("[TB] reset state and free-running fetch");
      applyStimulus(1, 0, 0, 32'h0, 0);
      for (int i = 0; i < 14; i++) applyStimulus(0, 1, 0, 32'h0, 0);

      $display("[TB] stalled start fills queue then drains");
      applyStimulus(1, 0, 0, 32'h0, 0);
      for (int i = 0; i < 10; i++) applyStimulus(0, 1, 0, 32'h0, 1);
      checkOutput("freezeAddr", imemAddr, 32'h10);
      checkOutput("fullCount", 32'(countOut), 32'd4);
      for (int i = 0; i < 10; i++) applyStimulus(0, 1, 0, 32'h0, 0);

      $display("[TB] full queue with continuous fetch across wraps");
      for (int i = 0; i < 6; i++) applyStimulus(0, 1, 0, 32'h0, 1);
      for (int i = 0; i < 16; i++) applyStimulus(0, 1, 0, 32'h0, 0);

      $display("[TB] redirect with three entries held");
      applyStimulus(1, 0, 0, 32'h0, 0);
      for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 32'h0, 1);
      applyStimulus(0, 1, 1, 32'h103, 1);
      @(posedge clk);
      #1;
      checkOutput("redirAddr", imemAddr, 32'h100);
      checkOutput("redirCount", 32'(countOut), 32'd0);
      for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 32'h0, 0);

      $display("[TB] reset coincident with redirect");
      applyStimulus(1, 1, 1, 32'h200, 0);
      applyStimulus(0, 0, 0, 32'h0, 0);

      $display("[TB] fetch PC wraparound and stop while draining");
      applyStimulus(0, 1, 1, 32'hFFFF_FFF8, 1);
      for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 32'h0, 1);
      for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 32'h0, 0);
      checkOutput("drainCount", 32'(countOut), 32'd0);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 500; i++) begin
         applyStimulus(($urandom_range(0, 63) == 0),
                       ($urandom_range(0, 7) != 0),
                       ($urandom_range(0, 9) == 0),
                       $urandom(),
                       ($urandom_range(0, 2) == 0));
      end

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
